// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage RV32I pipeline control logic.
//   hazard_state_t : state of the hazard sequencer
//   NOP_INSTR      : encoding of addi x0,x0,0 used for IF/ID bubbles
//   REG_ADDR_W     : register index width
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        IF_WAIT  = 3'd2,
        MEM_WAIT = 3'd3,
        REDIRECT = 3'd4
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          REG_ADDR_W = 5;

endpackage : pipeline_pkg

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : add one this cycle (ignored once saturated)
//   clr   : synchronous clear, wins over inc
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage RV32I pipeline. Every cycle it
// decides whether PC and IF/ID advance, hold or take a bubble, whether ID/EX
// takes a bubble and whether the back end freezes. Controls are combinational
// from the registered state and the current inputs so they steer the same-cycle
// register updates. Also keeps saturating stall/flush counters and a sticky
// fetch-timeout flag.
//
// Ports
//   clk, rst              : clock (rising) / asynchronous active-high reset
//   idRs1, idRs2          : source registers of the ID instruction
//   idUsesRs1, idUsesRs2  : ID instruction actually reads rs1 / rs2
//   exMemRead, exRd       : EX instruction is a load / its destination
//   exRedirect            : taken branch/jump resolved in EX
//   imemReady             : instruction memory delivers this cycle
//   dmemBusy              : data memory not done, MEM must hold
//   pcWrite, ifIdWrite    : PC / IF/ID load enables
//   ifIdBubble            : IF/ID loads a NOP (overrides ifIdWrite)
//   idExBubble            : ID/EX loads a NOP control word
//   backFreeze            : ID/EX, EX/MEM, MEM/WB hold
//   stallCycles           : cycles with pcWrite=0 (saturating)
//   flushCount            : number of redirects (saturating)
//   fetchTimeout          : sticky, set after FETCH_TIMEOUT consecutive waits
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W    = pipeline_pkg::REG_ADDR_W,
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exRedirect,
    input  logic                  imemReady,
    input  logic                  dmemBusy,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  ifIdBubble,
    output logic                  idExBubble,
    output logic                  backFreeze,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount,
    output logic                  fetchTimeout
);

    // The wait counter must be able to hold any legal FETCH_TIMEOUT value.
    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(FETCH_TIMEOUT - 1);

    hazard_state_t     state_reg;
    hazard_state_t     state_next;
    logic              fetch_timeout_reg;
    logic [WAIT_W-1:0] wait_count;

    logic load_use;
    logic sel_mem;
    logic sel_redirect;
    logic sel_lu;
    logic sel_fetch;
    logic wait_inc;
    logic wait_clr;
    logic stall_inc;

    // -------------------------------------------------------------------------
    // Hazard detection. x0 is never a real producer, so exRd==0 cannot stall.
    // -------------------------------------------------------------------------
    always_comb begin
        load_use = exMemRead && (exRd != '0) &&
                   ((idUsesRs1 && (idRs1 == exRd)) ||
                    (idUsesRs2 && (idRs2 == exRd)));
    end

    // -------------------------------------------------------------------------
    // Priority selection, highest first. A frozen back end keeps the EX
    // inputs stable, so a pending redirect or load-use is re-seen afterwards.
    // In REDIRECT the ID slot holds a bubble, so load-use there is spurious.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_mem      = dmemBusy;
        sel_redirect = !dmemBusy && exRedirect;
        sel_lu       = !dmemBusy && !exRedirect && load_use &&
                       (state_reg != REDIRECT);
        sel_fetch    = !dmemBusy && !exRedirect && !sel_lu && !imemReady;
    end

    // -------------------------------------------------------------------------
    // Control outputs and next state.
    // -------------------------------------------------------------------------
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdBubble = 1'b0;
        idExBubble = 1'b0;
        backFreeze = 1'b0;
        state_next = RUN;

        if (sel_mem) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            backFreeze = 1'b1;
            state_next = MEM_WAIT;
        end else if (sel_redirect) begin
            ifIdBubble = 1'b1;
            idExBubble = 1'b1;
            state_next = REDIRECT;
        end else if (sel_lu) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            state_next = LU_STALL;
        end else if (sel_fetch) begin
            pcWrite    = 1'b0;
            ifIdBubble = 1'b1;
            state_next = IF_WAIT;
        end

        // Reset overrides everything: keep the pipeline filled with bubbles.
        if (rst) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdBubble = 1'b1;
            idExBubble = 1'b1;
            backFreeze = 1'b0;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch-wait tracking. The wait count holds while the data side freezes
    // the pipeline; otherwise any cycle that is not a fetch wait clears it.
    // -------------------------------------------------------------------------
    always_comb begin
        wait_inc  = sel_fetch;
        wait_clr  = !dmemBusy && !sel_fetch;
        stall_inc = !rst && !pcWrite;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_timeout_reg <= 1'b0;
        end else if (wait_inc && (wait_count >= TIMEOUT_M1)) begin
            fetch_timeout_reg <= 1'b1;
        end
    end

    assign fetchTimeout = fetch_timeout_reg;

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sel_redirect),
        .clr   (1'b0),
        .count (flushCount)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .count (wait_count)
    );

endmodule : pipeline_hazard_controller

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. Decides each cycle whether the PC and IF/ID register advance, hold, or take a bubble (addi x0,x0,0), and whether ID/EX takes a bubble. Sources are load-use hazards, taken branches/jumps resolved in EX, instruction-memory wait, and data-memory busy. Also keeps stall/flush performance counters and a sticky fetch-timeout error flag.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of the performance counters
FETCH_TIMEOUT, 64, consecutive IF_WAIT cycles before fetchTimeout is set (must be 1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
idRs1  in  REG_ADDR_W  rs1 of the instruction in ID
idRs2  in  REG_ADDR_W  rs2 of the instruction in ID
idUsesRs1  in  1  ID instruction reads rs1
idUsesRs2  in  1  ID instruction reads rs2
exMemRead  in  1  instruction in EX is a load
exRd  in  REG_ADDR_W  destination register of the instruction in EX
exRedirect  in  1  taken branch or jump resolved in EX this cycle
imemReady  in  1  instruction memory returns valid data this cycle
dmemBusy  in  1  data memory not done; MEM must hold
pcWrite  out  1  1 = PC loads next value
ifIdWrite  out  1  1 = IF/ID loads pc/instruction; 0 = hold
ifIdBubble  out  1  1 = IF/ID loads NOP (overrides ifIdWrite)
idExBubble  out  1  1 = ID/EX loads NOP control word
backFreeze  out  1  1 = ID/EX, EX/MEM, MEM/WB hold
stallCycles  out  CNT_W  cycles with pcWrite=0, saturating
flushCount  out  CNT_W  number of redirects, saturating
fetchTimeout  out  1  sticky error flag

Behaviour:
- States: RUN, LU_STALL, IF_WAIT, MEM_WAIT, REDIRECT. The state register and counters use async rst.
- Outputs are combinational from the registered state and the current inputs: zero-latency control into the same-cycle register updates.
- While rst=1: pcWrite=0, ifIdWrite=0, ifIdBubble=1, idExBubble=1, backFreeze=0. Counters are 0, fetchTimeout=0, state=RUN.
- Reset mid-operation discards any stall in progress. The first cycle after release evaluates from RUN.
- loadUse = exMemRead & (exRd!=0) & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
- Per-cycle priority, highest first. The default output values are pcWrite=1, ifIdWrite=1, all others 0.
  1. dmemBusy: pcWrite=0, ifIdWrite=0, backFreeze=1, next=MEM_WAIT. Taken redirect and load-use are held, not lost, because the EX inputs are frozen.
  2. exRedirect: pcWrite=1 (target), ifIdBubble=1, idExBubble=1, flushCount++, next=REDIRECT.
  3. loadUse, and state!=REDIRECT: pcWrite=0, ifIdWrite=0, idExBubble=1, next=LU_STALL.
  4. !imemReady: pcWrite=0, ifIdBubble=1, next=IF_WAIT.
  5. Otherwise: next=RUN.
- REDIRECT lasts exactly one cycle. loadUse is masked there because the ID slot is a bubble.
- LU_STALL lasts one cycle: EX now holds a bubble, so loadUse deasserts. A new loadUse in LU_STALL is legal and re-stalls.
- IF_WAIT tracks a wait counter. It resets to 0 on any cycle with imemReady=1 or on leaving IF_WAIT.
  - When the counter reaches FETCH_TIMEOUT, fetchTimeout is set to 1 and stays 1 until rst.
  - The counter saturates.
- dmemBusy during IF_WAIT: MEM_WAIT takes priority and the wait counter holds.
- stallCycles increments on every non-reset cycle with pcWrite=0. Both counters saturate at all-ones and never wrap.
- exRedirect coinciding with !imemReady: the redirect wins. Fetch wait is re-evaluated in the next cycle.

Decomposition:
- The shared package pipeline_pkg holds:
  - the typedef enum hazard_state_t {RUN, LU_STALL, IF_WAIT, MEM_WAIT, REDIRECT};
  - the constant NOP_INSTR = 32'h00000013;
  - the constant REG_ADDR_W = 5.
- One sub-module, sat_counter (parameterised width, inc, clr, saturating), instantiated three times: stallCycles, flushCount, fetch-wait counter.
- The hazard-compare and priority logic stays in the top module.

Test Plan:
- Reset: rst=1 with random inputs → pcWrite=0, ifIdBubble=1, idExBubble=1, counters 0. Release → RUN; with no hazards, pcWrite=1 and ifIdWrite=1.
- Load-use: exMemRead=1, exRd=5, idRs2=5, idUsesRs2=1 → one cycle with pcWrite=0, ifIdWrite=0, idExBubble=1. Next cycle (exMemRead=0) → pcWrite=1; stallCycles=1.
- exRd=0 with idRs1=0 and a load → no stall. Redirect and loadUse in the same cycle → redirect outputs, flushCount=1, no LU_STALL; next cycle loadUse is masked.
- dmemBusy=1 for 3 cycles with exRedirect=1 held → backFreeze=1 and pcWrite=0 for 3 cycles. The 4th cycle shows redirect outputs; flushCount=1, stallCycles=3.
- imemReady=0 for FETCH_TIMEOUT cycles → ifIdBubble=1 each cycle and fetchTimeout=1 after cycle 64. It stays 1 after imemReady returns and clears only on rst.
- Counter saturation with CNT_W=4: 20 stall cycles → stallCycles=15, no wrap. rst mid-IF_WAIT → state RUN and counters 0 asynchronously.
